wb_regfile: RTL and testbench

//  Write-back end of the MEM/WB pipeline interface. Consumes the MEM/WB register

---
 rtl/wb_regfile_if.sv | 31 +++
 rtl/wb_regfile.sv | 68 ++++++
 tb/tb_wb_regfile.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// Write-back / register-read bus between the MEM/WB register, the ID stage and the
// register bank.
//   master: drives RegWrite, MemtoReg, toAW, tMux5_1, tMux5_0, RR1, RR2
//           and receives RD1, RD2, wbData, wbValid
//   slave : the register bank (wb_regfile), which is the opposite side
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWrite;
  logic              MemtoReg;
  logic [ADDR_W-1:0] toAW;
  logic [DATA_W-1:0] tMux5_1;
  logic [DATA_W-1:0] tMux5_0;
  logic [ADDR_W-1:0] RR1;
  logic [ADDR_W-1:0] RR2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] wbData;
  logic              wbValid;

  modport master (
    output RegWrite, MemtoReg, toAW, tMux5_1, tMux5_0, RR1, RR2,
    input  RD1, RD2, wbData, wbValid
  );

  modport slave (
    input  RegWrite, MemtoReg, toAW, tMux5_1, tMux5_0, RR1, RR2,
    output RD1, RD2, wbData, wbValid
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back end of the MEM/WB pipeline: selects the write-back datum, commits it to
// a 2^ADDR_W x DATA_W register bank (entry 0 hardwired to zero) and serves two
// combinational read ports with same-cycle write-to-read bypass.
//   clkWB   : clock, all state updates on posedge
//   rstnWB  : synchronous reset, active low, clears the whole bank
//   wbIf    : slave side of wb_regfile_if
//             in : RegWrite, MemtoReg, toAW, tMux5_1, tMux5_0, RR1, RR2
//             out: RD1, RD2, wbData, wbValid (all combinational)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic          clkWB,
  input  logic          rstnWB,
  wb_regfile_if.slave   wbIf
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] bank [NUM_REGS];
  logic [DATA_W-1:0] wbDataSel;
  logic              wbValidSel;
  logic              bypass1;
  logic              bypass2;

  // Write-back mux and write qualifier; index 0 never counts as a real write.
  always_comb begin
    wbDataSel  = wbIf.MemtoReg ? wbIf.tMux5_1 : wbIf.tMux5_0;
    wbValidSel = wbIf.RegWrite && (wbIf.toAW != ADDR_W'(0));
  end

  assign wbIf.wbData  = wbDataSel;
  assign wbIf.wbValid = wbValidSel;

  // Bank storage: reset wins over a simultaneous write.
  always_ff @(posedge clkWB) begin
    if (!rstnWB) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        bank[i] <= DATA_W'(0);
      end
    end else if (wbValidSel) begin
      bank[wbIf.toAW] <= wbDataSel;
    end
  end

  // Bypass is gated by reset so a read never sees a write that reset is about to drop.
  always_comb begin
    bypass1 = wbValidSel && rstnWB && (wbIf.toAW == wbIf.RR1);
    bypass2 = wbValidSel && rstnWB && (wbIf.toAW == wbIf.RR2);
  end

  // Read port 1.
  always_comb begin
    wbIf.RD1 = DATA_W'(0);
    if (wbIf.RR1 != ADDR_W'(0)) begin
      wbIf.RD1 = bypass1 ? wbDataSel : bank[wbIf.RR1];
    end
  end

  // Read port 2.
  always_comb begin
    wbIf.RD2 = DATA_W'(0);
    if (wbIf.RR2 != ADDR_W'(0)) begin
      wbIf.RD2 = bypass2 ? wbDataSel : bank[wbIf.RR2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, randomized traffic against an
// array-based model, and a back-to-back fill/readback sequence.
module tb_wb_regfile;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic clk;
  logic rstn;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clkWB  (clk),
    .rstnWB (rstn),
    .wbIf   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol check: MemtoReg must be known whenever a write is requested.
  always @(posedge clk) begin
    if (rstn === 1'b1 && bus.RegWrite === 1'b1)
      assert (!$isunknown(bus.MemtoReg)) else $error("MemtoReg unknown during write");
  end

  int checks = 0;
  int errors = 0;

  // Reference register contents (index 0 is never consulted).
  logic [31:0] model [32];

  typedef struct {
    logic        rst_n;
    logic        rw;
    logic        m2r;
    logic [4:0]  aw;
    logic [31:0] d1;
    logic [31:0] d0;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] expRd1;
    logic [31:0] expRd2;
    logic [31:0] expWb;
    logic        expValid;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rw, input logic m2r, input logic [4:0] aw,
                       input logic [31:0] d1, input logic [31:0] d0,
                       input logic [4:0] rr1, input logic [4:0] rr2);
    rstn         = r;
    bus.RegWrite = rw;
    bus.MemtoReg = m2r;
    bus.toAW     = aw;
    bus.tMux5_1  = d1;
    bus.tMux5_0  = d0;
    bus.RR1      = rr1;
    bus.RR2      = rr2;
  endtask

  // Take one clock edge and apply the architectural effect to the model.
  task automatic tick();
    logic [31:0] wv;
    wv = bus.MemtoReg ? bus.tMux5_1 : bus.tMux5_0;
    @(posedge clk);
    if (!rstn) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus.RegWrite && bus.toAW != 5'd0) begin
      model[bus.toAW] = wv;
    end
    @(negedge clk);
  endtask

  // Expected read value from the model given the currently driven inputs.
  function automatic logic [31:0] expRead(input logic [4:0] rr);
    logic [31:0] wv;
    wv = bus.MemtoReg ? bus.tMux5_1 : bus.tMux5_0;
    if (rr == 5'd0) return 32'h0;
    if (rstn && bus.RegWrite && bus.toAW == rr) return wv;
    return model[rr];
  endfunction

  task automatic chkModel(input string tag);
    logic [31:0] wv;
    wv = bus.MemtoReg ? bus.tMux5_1 : bus.tMux5_0;
    #1;
    chk({tag, " wbData"}, bus.wbData, wv);
    chk({tag, " wbValid"}, 32'(bus.wbValid), 32'(bus.RegWrite && bus.toAW != 5'd0));
    chk({tag, " RD1"}, bus.RD1, expRead(bus.RR1));
    chk({tag, " RD2"}, bus.RD2, expRead(bus.RR2));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd5, 32'h0,        32'h1234_5678, 5'd5, 5'd0, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFF_FFFF, 32'h0,        5'd5, 5'd5, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0,        5'd9, 5'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 5'd9, 32'h0,        32'h0,         5'd9, 5'd5, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        32'hFFFF_FFFF, 5'd0, 5'd0, 32'h0,         32'h0,         32'hFFFF_FFFF, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 5'd0, 32'h0,        32'h0,         5'd0, 5'd9, 32'h0,         32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'd3, 32'h0,        32'hA5A5_A5A5, 5'd3, 5'd3, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 5'd3, 32'h0,        32'h0,         5'd3, 5'd5, 32'hA5A5_A5A5, 32'h1234_5678, 32'h0,         1'b0};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 5'd3, 32'h0,        32'h1111_1111, 5'd3, 5'd5, 32'hA5A5_A5A5, 32'h1234_5678, 32'h1111_1111, 1'b1};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 5'd3, 32'h0,        32'h0,         5'd3, 5'd5, 32'h0,         32'h0,         32'h0,         1'b0};

    // Reset held for two edges, then sweep both read ports with reset still low.
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    tick();
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.RR1 = 5'(i);
      bus.RR2 = 5'(31 - i);
      #1;
      chk($sformatf("reset RD1[%0d]", i), bus.RD1, 32'h0);
      chk($sformatf("reset RD2[%0d]", 31 - i), bus.RD2, 32'h0);
    end

    // Directed table: ALU write, mem write + bypass, zero register, reset vs write.
    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rst_n, vecs[v].rw, vecs[v].m2r, vecs[v].aw,
            vecs[v].d1, vecs[v].d0, vecs[v].rr1, vecs[v].rr2);
      #1;
      chk($sformatf("vec%0d RD1", v), bus.RD1, vecs[v].expRd1);
      chk($sformatf("vec%0d RD2", v), bus.RD2, vecs[v].expRd2);
      chk($sformatf("vec%0d wbData", v), bus.wbData, vecs[v].expWb);
      chk($sformatf("vec%0d wbValid", v), 32'(bus.wbValid), 32'(vecs[v].expValid));
      tick();
    end

    // Randomized traffic with occasional reset, checked against the model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom), 5'($urandom),
            $urandom, $urandom, 5'($urandom), 5'($urandom));
      if (($urandom_range(0, 3) == 0)) bus.RR1 = bus.toAW;
      if (($urandom_range(0, 3) == 0)) bus.RR2 = bus.toAW;
      chkModel($sformatf("rand%0d", n));
      tick();
    end

    // Back-to-back fill of entries 1..31, then read back in pairs.
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 1'b0, 5'(i), 32'h0, 32'(i) * 32'h0101_0101, 5'd0, 5'd0);
      tick();
    end
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'(i), 5'(32 - i));
      #1;
      chk($sformatf("fill RD1[%0d]", i), bus.RD1, 32'(i) * 32'h0101_0101);
      chk($sformatf("fill RD2[%0d]", 32 - i), bus.RD2, 32'(32 - i) * 32'h0101_0101);
    end
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'hCAFE_F00D, 32'h0, 5'd30, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd31, 5'd30);
    #1;
    chk("overwrite RD1[31]", bus.RD1, 32'hCAFE_F00D);
    chk("overwrite RD2[30]", bus.RD2, 32'd30 * 32'h0101_0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
